// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage between execute and write-back. Non-memory
// instructions pass their ALU result straight through to write-back one cycle
// after acceptance. Loads and stores are issued to a variable-latency data
// memory over a req/ready handshake. Store data is replicated into byte lanes
// with matching byte enables. Load data is lane-selected and sign- or
// zero-extended. Misaligned or malformed memory ops never reach memory. They
// retire with a one-cycle mem_err pulse instead.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   in_valid / in_ready       execute handshake (in_ready == state is IDLE)
//   in_mem_read/in_mem_write  load / store qualifiers
//   in_funct3                 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   in_reg_write, in_rd       destination register control
//   alu_data                  ALU result / byte address
//   memory_data               store data (rs2)
//   dmem_req/we/addr/be/wdata request to data memory, held until dmem_ready
//   dmem_ready, dmem_rdata    memory completion and load word
//   wb_valid/reg_write/rd/data registered result to write-back (1-cycle pulse)
//   mem_err                   1-cycle pulse with wb_valid for an illegal access
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [2:0]            in_funct3,
  input  logic                  in_reg_write,
  input  logic [4:0]            in_rd,
  input  logic [ADDR_WIDTH-1:0] alu_data,
  input  logic [31:0]           memory_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [31:0]           dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  mem_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, next_state;

  // Instruction context kept while the access is outstanding.
  logic [1:0] lat_lane;
  logic [2:0] lat_funct3;
  logic [4:0] lat_rd;
  logic       lat_reg_write;

  logic        accept;
  logic        is_mem;
  logic        funct3_bad;
  logic        misaligned;
  logic        illegal;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  // Derived from state so that an asynchronous reset drops the request at
  // once, without waiting for a clock edge.
  assign dmem_req = (state == ACCESS);

  // ---------------------------------------------------------------------------
  // Decode and legality of the incoming instruction
  // ---------------------------------------------------------------------------
  assign is_mem = in_mem_read | in_mem_write;

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    funct3_bad = 1'b0;
    unique case (in_funct3)
      3'b011, 3'b110, 3'b111: funct3_bad = 1'b1;
      default:                funct3_bad = 1'b0;
    endcase
  end

  // Halfwords need addr[0]==0 and words need addr[1:0]==0. The funct3 values
  // that would reach the word check with bit 2 set are already rejected.
  assign misaligned = ((in_funct3[1:0] == 2'b01) && alu_data[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (alu_data[1:0] != 2'b00));

  assign illegal = is_mem &&
                   ((in_mem_read && in_mem_write) || funct3_bad || misaligned);

  // ---------------------------------------------------------------------------
  // Store lane alignment. Loads use the same byte-enable mask.
  // ---------------------------------------------------------------------------
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = memory_data;
    unique case (in_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << alu_data[1:0];
        wdata_next = {4{memory_data[7:0]}};
      end
      2'b01: begin
        be_next    = alu_data[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{memory_data[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = memory_data;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane selection and extension
  // ---------------------------------------------------------------------------
  assign ld_byte = dmem_rdata[{lat_lane, 3'b000} +: 8];
  assign ld_half = lat_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_ext = dmem_rdata;
    unique case (lat_funct3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'h0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'h0, ld_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (accept && is_mem && !illegal) next_state = ACCESS;
      ACCESS: if (dmem_ready)                   next_state = IDLE;
      default:                                  next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request and write-back registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: datapath registers are reset too, because write-back and memory
      // observe them directly and must see defined zeros out of reset.
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= 4'b0000;
      dmem_wdata    <= 32'h0;
      lat_lane      <= 2'b00;
      lat_funct3    <= 3'b000;
      lat_rd        <= 5'd0;
      lat_reg_write <= 1'b0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 32'h0;
      mem_err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= in_reg_write;
            wb_rd        <= in_rd;
            wb_data      <= 32'(alu_data);
          end else if (illegal) begin
            wb_valid     <= 1'b1;
            mem_err      <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_rd        <= in_rd;
            wb_data      <= 32'(alu_data);
          end else begin
            dmem_we       <= in_mem_write;
            dmem_addr     <= {alu_data[ADDR_WIDTH-1:2], 2'b00};
            dmem_be       <= be_next;
            dmem_wdata    <= wdata_next;
            lat_lane      <= alu_data[1:0];
            lat_funct3    <= in_funct3;
            lat_rd        <= in_rd;
            // Stores never write a register.
            lat_reg_write <= in_reg_write & in_mem_read;
          end
        end
      end else if (dmem_ready) begin
        wb_valid     <= 1'b1;
        wb_reg_write <= lat_reg_write;
        wb_rd        <= lat_rd;
        wb_data      <= dmem_we ? 32'h0 : load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed self-checking bench for mem_access_stage. Inputs are driven and
// outputs are sampled on the falling clock edge. All expected values are
// written out by hand from the intended behaviour.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [31:0] alu_data;
  logic [31:0] memory_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  int tests = 0;
  int fails = 0;

  mem_access_stage #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mem_read  (in_mem_read),
    .in_mem_write (in_mem_write),
    .in_funct3    (in_funct3),
    .in_reg_write (in_reg_write),
    .in_rd        (in_rd),
    .alu_data     (alu_data),
    .memory_data  (memory_data),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one instruction (in_valid=1) on the execute side.
  task automatic drive(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic rw, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] data);
    in_valid     = 1'b1;
    in_mem_read  = rd_op;
    in_mem_write = wr_op;
    in_funct3    = f3;
    in_reg_write = rw;
    in_rd        = rd;
    alu_data     = alu;
    memory_data  = data;
  endtask

  // Issue a load with zero-wait memory and check lanes and extension.
  task automatic load_zero_wait(input string tag, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] expected);
    drive(1'b1, 1'b0, f3, 1'b1, 5'd7, addr, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " req"}, {31'h0, dmem_req}, 32'd1);
    check({tag, " be"},  {28'h0, dmem_be}, {28'h0, be});
    @(negedge clk);
    check({tag, " wb_valid"}, {31'h0, wb_valid}, 32'd1);
    check({tag, " wb_data"},  wb_data, expected);
  endtask

  // Expected write-back stream for the back-to-back section.
  logic [4:0]  exp_rd   [3];
  logic        exp_rw   [3];
  logic [31:0] exp_data [3];

  initial begin
    int  k;
    int  nwb;
    logic acc_pending;

    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_mem_read  = 1'b0;
    in_mem_write = 1'b0;
    in_funct3    = 3'b000;
    in_reg_write = 1'b0;
    in_rd        = 5'd0;
    alu_data     = 32'h0;
    memory_data  = 32'h0;
    dmem_ready   = 1'b0;
    dmem_rdata   = 32'h0;

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    check("rst in_ready", {31'h0, in_ready}, 32'd1);
    check("rst dmem_req", {31'h0, dmem_req}, 32'd0);
    check("rst wb_valid", {31'h0, wb_valid}, 32'd0);
    check("rst mem_err",  {31'h0, mem_err},  32'd0);
    check("rst wb_data",  wb_data, 32'h0);
    check("rst dmem_be",  {28'h0, dmem_be}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- ADD passthrough ----
    drive(1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 32'h0000_1234, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("add wb_valid",     {31'h0, wb_valid}, 32'd1);
    check("add wb_data",      wb_data, 32'h0000_1234);
    check("add wb_rd",        {27'h0, wb_rd}, 32'd5);
    check("add wb_reg_write", {31'h0, wb_reg_write}, 32'd1);
    check("add dmem_req",     {31'h0, dmem_req}, 32'd0);
    @(negedge clk);
    check("add pulse width",  {31'h0, wb_valid}, 32'd0);

    // ---- SB at 0x103 with 3 wait cycles ----
    drive(1'b0, 1'b1, 3'b000, 1'b1, 5'd9, 32'h0000_0103, 32'hAABB_CCDD);
    @(negedge clk);
    in_valid = 1'b0;
    check("sb req",   {31'h0, dmem_req}, 32'd1);
    check("sb we",    {31'h0, dmem_we}, 32'd1);
    check("sb addr",  dmem_addr, 32'h0000_0100);
    check("sb be",    {28'h0, dmem_be}, 32'h8);
    check("sb wdata", dmem_wdata, 32'hDDDD_DDDD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sb wait in_ready", {31'h0, in_ready}, 32'd0);
      check("sb wait req",      {31'h0, dmem_req}, 32'd1);
      check("sb wait addr",     dmem_addr, 32'h0000_0100);
      check("sb wait wb_valid", {31'h0, wb_valid}, 32'd0);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    check("sb wb_valid",     {31'h0, wb_valid}, 32'd1);
    check("sb wb_reg_write", {31'h0, wb_reg_write}, 32'd0);
    check("sb in_ready",     {31'h0, in_ready}, 32'd1);
    check("sb req dropped",  {31'h0, dmem_req}, 32'd0);

    // ---- Zero-wait loads from word 0x8000_80F0 ----
    dmem_rdata = 32'h8000_80F0;
    dmem_ready = 1'b1;
    load_zero_wait("lb2",  3'b000, 32'h0000_0002, 4'b0100, 32'h0000_0000);
    load_zero_wait("lb3",  3'b000, 32'h0000_0003, 4'b1000, 32'hFFFF_FF80);
    load_zero_wait("lbu3", 3'b100, 32'h0000_0003, 4'b1000, 32'h0000_0080);
    load_zero_wait("lhu2", 3'b101, 32'h0000_0002, 4'b1100, 32'h0000_8000);
    load_zero_wait("lh0",  3'b001, 32'h0000_0000, 4'b0011, 32'hFFFF_80F0);
    load_zero_wait("lw0",  3'b010, 32'h0000_0000, 4'b1111, 32'h8000_80F0);
    check("lw wb_rd", {27'h0, wb_rd}, 32'd7);
    check("lw we",    {31'h0, dmem_we}, 32'd0);
    dmem_ready = 1'b0;

    // ---- Illegal ops: misaligned LW, misaligned SH, bad funct3 ----
    drive(1'b1, 1'b0, 3'b010, 1'b1, 5'd3, 32'h0000_0102, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("lw mis mem_err",   {31'h0, mem_err}, 32'd1);
    check("lw mis wb_valid",  {31'h0, wb_valid}, 32'd1);
    check("lw mis reg_write", {31'h0, wb_reg_write}, 32'd0);
    check("lw mis req",       {31'h0, dmem_req}, 32'd0);
    check("lw mis in_ready",  {31'h0, in_ready}, 32'd1);
    @(negedge clk);
    check("mis pulse width",  {31'h0, mem_err}, 32'd0);
    drive(1'b0, 1'b1, 3'b001, 1'b0, 5'd4, 32'h0000_0101, 32'h1234_5678);
    @(negedge clk);
    in_valid = 1'b0;
    check("sh mis mem_err",   {31'h0, mem_err}, 32'd1);
    check("sh mis wb_valid",  {31'h0, wb_valid}, 32'd1);
    check("sh mis req",       {31'h0, dmem_req}, 32'd0);
    drive(1'b1, 1'b0, 3'b011, 1'b1, 5'd4, 32'h0000_0100, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("f3 011 mem_err",   {31'h0, mem_err}, 32'd1);
    check("f3 011 reg_write", {31'h0, wb_reg_write}, 32'd0);
    drive(1'b1, 1'b1, 3'b010, 1'b1, 5'd4, 32'h0000_0100, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("rd+wr mem_err",    {31'h0, mem_err}, 32'd1);
    check("rd+wr req",        {31'h0, dmem_req}, 32'd0);

    // ---- Reset during ACCESS ----
    drive(1'b1, 1'b0, 3'b010, 1'b1, 5'd11, 32'h0000_0200, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort req before", {31'h0, dmem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check("abort req async", {31'h0, dmem_req}, 32'd0);
    dmem_ready = 1'b1;
    @(negedge clk);
    reset_n    = 1'b1;
    dmem_ready = 1'b0;
    check("abort in_ready", {31'h0, in_ready}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort wb_valid", {31'h0, wb_valid}, 32'd0);
      check("abort mem_err",  {31'h0, mem_err}, 32'd0);
    end
    dmem_rdata = 32'h1234_5678;
    dmem_ready = 1'b1;
    load_zero_wait("post-rst lw", 3'b010, 32'h0000_0200, 4'b1111, 32'h1234_5678);
    check("post-rst wb_rd", {27'h0, wb_rd}, 32'd7);

    // ---- Back-to-back LW, SW, ADD with in_valid held high ----
    dmem_rdata  = 32'hCAFE_F00D;
    exp_rd[0]   = 5'd1; exp_rw[0] = 1'b1; exp_data[0] = 32'hCAFE_F00D;
    exp_rd[1]   = 5'd2; exp_rw[1] = 1'b0; exp_data[1] = 32'h0;
    exp_rd[2]   = 5'd3; exp_rw[2] = 1'b1; exp_data[2] = 32'h0000_0777;
    @(negedge clk);
    k   = 0;
    nwb = 0;
    drive(1'b1, 1'b0, 3'b010, 1'b1, 5'd1, 32'h0000_0010, 32'h0);
    acc_pending = in_ready;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (wb_valid) begin
        if (nwb < 3) begin
          check("b2b wb_rd",        {27'h0, wb_rd}, {27'h0, exp_rd[nwb]});
          check("b2b wb_reg_write", {31'h0, wb_reg_write}, {31'h0, exp_rw[nwb]});
          if (exp_rw[nwb]) check("b2b wb_data", wb_data, exp_data[nwb]);
        end
        nwb++;
      end
      if (acc_pending) begin
        k++;
        if (k == 1)      drive(1'b0, 1'b1, 3'b010, 1'b1, 5'd2, 32'h0000_0014, 32'h0000_0011);
        else if (k == 2) drive(1'b0, 1'b0, 3'b000, 1'b1, 5'd3, 32'h0000_0777, 32'h0);
        else             in_valid = 1'b0;
      end
      acc_pending = in_valid && in_ready;
    end
    check("b2b accepted", k, 32'd3);
    check("b2b wb pulses", nwb, 32'd3);
    dmem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It takes the ALU result (address or passthrough data) and store data from execute, and performs loads and stores against a variable-latency data memory through a req/ready handshake. It aligns store data into byte lanes and sign- or zero-extends load data. While an access is outstanding it back-pressures execute, and it presents one registered result per instruction to write-back.

## Interface
- ADDR_WIDTH, 32, byte-address width of alu_data and dmem_addr
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute presents an instruction this cycle
- in_ready  out  1  stage can accept; combinational, equal to (state == IDLE)
- in_mem_read  in  1  instruction is a load
- in_mem_write  in  1  instruction is a store
- in_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_reg_write  in  1  instruction writes rd
- in_rd  in  5  destination register
- alu_data  in  ADDR_WIDTH  ALU result; the byte address for memory ops
- memory_data  in  32  store data (rs2)
- dmem_req  out  1  access request, held until dmem_ready
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_WIDTH  word-aligned address {alu_data[ADDR_WIDTH-1:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  access completes this cycle
- dmem_rdata  in  32  load word; valid when dmem_req && dmem_ready
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_reg_write  out  1  write-back enable
- wb_rd  out  5  destination register
- wb_data  out  32  load result or alu_data passthrough
- mem_err  out  1  one-cycle pulse, coincident with wb_valid, for a misaligned or illegal access

## Operation
- FSM has two states, IDLE and ACCESS. Reset state is IDLE.
- An instruction is accepted when in_valid && in_ready.
- IDLE, accept of a non-memory op: on the next edge, wb_valid=1, wb_data=alu_data, wb_rd=in_rd, wb_reg_write=in_reg_write. The FSM stays in IDLE.
- IDLE, accept of a legal, aligned memory op: latch the address, byte lane, funct3, rd, reg_write, be and wdata. The FSM moves to ACCESS.
- ACCESS: dmem_req=1 and request outputs are held stable. On dmem_ready, capture and extend dmem_rdata (loads only). The next edge pulses wb_valid and returns to IDLE.
- Illegal memory op: mem_err pulses with wb_valid on the next edge, with wb_reg_write=0. No dmem request is issued and the FSM stays in IDLE. An op is illegal if any of these hold:
  - in_mem_read and in_mem_write are both 1.
  - funct3 is 011, 110 or 111.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
- Stores complete with wb_reg_write=0 regardless of in_reg_write.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111, wdata = data.
- Load lanes:
  - LB/LBU select rdata byte addr[1:0], then sign- or zero-extend to 32 bits.
  - LH/LHU select rdata half addr[1], then sign- or zero-extend.
  - LW passes rdata through.
  - dmem_be for loads is the same mask as the equivalent store.
- dmem_ready is ignored while in IDLE.

## Timing
- Reset values: state IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write, mem_err = 0; dmem_addr, dmem_be, dmem_wdata, wb_rd, wb_data = 0. in_ready is 1 while in reset.
- Non-memory and illegal ops: accepted at edge N, wb_valid high in cycle N+1.
- Memory ops: accepted at edge N; dmem_req high from cycle N+1; dmem_ready seen in cycle M ≥ N+1; wb_valid in cycle M+1. Minimum latency is 2 cycles.
- dmem_ready in the same cycle dmem_req first rises (zero-wait memory) completes the access.
- in_ready is low from cycle N+1 through cycle M. It returns high in cycle M+1, so back-to-back issue is possible in M+1.
- Reset asserted during ACCESS aborts the access: dmem_req drops asynchronously, and no wb_valid or mem_err is produced.
- Every wb_valid pulse is exactly one cycle wide, and there is at most one per accepted instruction.

## Test plan
- ADD passthrough: alu_data=0x0000_1234, rd=5, reg_write=1 -> the next cycle shows wb_valid=1, wb_data=0x1234, wb_rd=5, and no dmem_req.
- SB at 0x103, data=0xAABB_CCDD -> dmem_addr=0x100, be=4'b1000, wdata=0xDDDD_DDDD, we=1. Hold ready low 3 cycles: in_ready=0 and request stable. Raise ready: wb_valid next cycle with wb_reg_write=0.
- Loads from word 0x8000_80F0 with zero-wait ready:
  - LB at 0x2: wb_data=0x0000_0000.
  - LB at 0x3: wb_data=0xFFFF_FF80.
  - LHU at 0x2: wb_data=0x0000_8000.
  - LH at 0x0: wb_data=0xFFFF_80F0.
  - LW: wb_data=0x8000_80F0.
- Misaligned LW at 0x102 and SH at 0x101 -> no dmem_req, mem_err=1 with wb_valid=1 one cycle later, wb_reg_write=0.
- Drop reset_n while in ACCESS -> dmem_req is 0 immediately. After release, in_ready=1, wb_valid stays 0, and a subsequent LW completes normally.
- Back-to-back LW, SW, ADD with in_valid held high -> each accepted only while in_ready=1, three wb_valid pulses in order, none lost or duplicated.
